// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
// Module   : core_pkg
// Purpose  : Shared definitions for the core register file and its debug
//            access port. Holds default sizes, the debug arbitration state
//            encoding and a read-port bundle type.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package core_pkg;

  localparam int XLEN_DEFAULT  = 32;
  localparam int NREGS_DEFAULT = 32;

  // Debug arbitration states
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_HALT = 2'd1,
    ACCESS    = 2'd2,
    RESP      = 2'd3
  } dbg_fsm_t;

  // One core read port as a bundle, for users that prefer an unpacked array
  // of ports over the flat packed vectors on the register file boundary.
  typedef struct packed {
    logic [$clog2(NREGS_DEFAULT)-1:0] addr;
    logic [XLEN_DEFAULT-1:0]          data;
  } rf_rd_port_t;

endpackage
`default_nettype wire

// File: rtl/regfile_dbg_fsm.sv
`default_nettype none
// ============================================================================
// Module   : regfile_dbg_fsm
// Purpose  : Debug access arbitration for the register file. Accepts a
//            request, waits for the core to halt, stalls while the WB stage
//            is still writing, then fires the access and returns an ack.
// Ports    : clk, rst_i          - clock, synchronous active-high reset
//            halt_i, wr_en_i     - core halted / WB write in flight
//            dbg_req_i, dbg_we_i, dbg_addr_i, dbg_wdata_i - debug request
//            access_go           - perform the captured access this cycle
//            cap_we, cap_addr, cap_oor, cap_wdata - captured request
//            dbg_ack_o, dbg_err_o, dbg_busy_o     - debug status
// Revision : 1.0 - initial release
// ============================================================================
module regfile_dbg_fsm
  import core_pkg::*;
#(
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int NREGS = NREGS_DEFAULT,
  parameter int AW    = $clog2(NREGS_DEFAULT)
) (
  input  logic            clk,
  input  logic            rst_i,
  input  logic            halt_i,
  input  logic            wr_en_i,
  input  logic            dbg_req_i,
  input  logic            dbg_we_i,
  input  logic [AW:0]     dbg_addr_i,
  input  logic [XLEN-1:0] dbg_wdata_i,
  output logic            access_go,
  output logic            cap_we,
  output logic [AW-1:0]   cap_addr,
  output logic            cap_oor,
  output logic [XLEN-1:0] cap_wdata,
  output logic            dbg_ack_o,
  output logic            dbg_err_o,
  output logic            dbg_busy_o
);

  dbg_fsm_t        state, state_nxt;
  logic            accept;
  logic            we_q;
  logic [AW:0]     addr_q;
  logic [XLEN-1:0] wdata_q;
  logic            err_q;

  // State register
  always_ff @(posedge clk) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (dbg_req_i) state_nxt = halt_i ? ACCESS : WAIT_HALT;
      WAIT_HALT: if (halt_i)    state_nxt = ACCESS;
      // Losing halt aborts back to waiting; a WB write holds us here.
      ACCESS: begin
        if (!halt_i)       state_nxt = WAIT_HALT;
        else if (!wr_en_i) state_nxt = RESP;
      end
      RESP:      state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    accept     = 1'b0;
    access_go  = 1'b0;
    dbg_ack_o  = 1'b0;
    dbg_busy_o = 1'b1;
    case (state)
      IDLE: begin
        dbg_busy_o = 1'b0;
        accept     = dbg_req_i;
      end
      ACCESS:  access_go = halt_i & ~wr_en_i;
      RESP:    dbg_ack_o = 1'b1;
      default: ;
    endcase
  end

  // Request fields are frozen at acceptance; the requester may change them
  // afterwards without affecting the transaction in flight.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      we_q    <= dbg_we_i;
      addr_q  <= dbg_addr_i;
      wdata_q <= dbg_wdata_i;
    end
  end

  // Error flag survives past the ack and is only cleared by the next request.
  always_ff @(posedge clk) begin
    if (rst_i)          err_q <= 1'b0;
    else if (accept)    err_q <= 1'b0;
    else if (access_go) err_q <= cap_oor;
  end

  assign cap_we    = we_q;
  assign cap_addr  = addr_q[AW-1:0];
  assign cap_oor   = (addr_q >= (AW+1)'(NREGS));
  assign cap_wdata = wdata_q;
  assign dbg_err_o = err_q;

endmodule
`default_nettype wire

// File: rtl/core_regfile_dbg.sv
`default_nettype none
// ============================================================================
// Module   : core_regfile_dbg
// Purpose  : Core register file with NUM_RD combinational read ports, one WB
//            write port (optional write-to-read bypass) and a handshaked
//            debug port serviced only while the core is halted.
// Ports    : clk, rst_i                   - clock, sync active-high reset
//            rd_addr_i / rd_data_o        - packed core read ports
//            wr_en_i, wr_addr_i, wr_data_i - core write port
//            halt_i                       - core halted
//            dbg_req_i, dbg_we_i, dbg_addr_i, dbg_wdata_i - debug request
//            dbg_rdata_o, dbg_ack_o, dbg_err_o, dbg_busy_o - debug response
// Revision : 1.0 - initial release
// ============================================================================
module core_regfile_dbg
  import core_pkg::*;
#(
  parameter  int XLEN       = XLEN_DEFAULT,
  parameter  int NREGS      = NREGS_DEFAULT,
  parameter  int NUM_RD     = 2,
  parameter  int BYPASS     = 1,
  parameter  int RESET_REGS = 1,
  localparam int AW         = $clog2(NREGS)
) (
  input  logic                   clk,
  input  logic                   rst_i,
  input  logic [NUM_RD*AW-1:0]   rd_addr_i,
  output logic [NUM_RD*XLEN-1:0] rd_data_o,
  input  logic                   wr_en_i,
  input  logic [AW-1:0]          wr_addr_i,
  input  logic [XLEN-1:0]        wr_data_i,
  input  logic                   halt_i,
  input  logic                   dbg_req_i,
  input  logic                   dbg_we_i,
  input  logic [AW:0]            dbg_addr_i,
  input  logic [XLEN-1:0]        dbg_wdata_i,
  output logic [XLEN-1:0]        dbg_rdata_o,
  output logic                   dbg_ack_o,
  output logic                   dbg_err_o,
  output logic                   dbg_busy_o
);

  logic [XLEN-1:0] regs [NREGS];

  logic            access_go;
  logic            cap_we;
  logic [AW-1:0]   cap_addr;
  logic            cap_oor;
  logic [XLEN-1:0] cap_wdata;
  logic            core_wr;
  logic            dbg_wr;
  logic [XLEN-1:0] rdata_q;

  regfile_dbg_fsm #(
    .XLEN  (XLEN),
    .NREGS (NREGS),
    .AW    (AW)
  ) u_fsm (
    .clk         (clk),
    .rst_i       (rst_i),
    .halt_i      (halt_i),
    .wr_en_i     (wr_en_i),
    .dbg_req_i   (dbg_req_i),
    .dbg_we_i    (dbg_we_i),
    .dbg_addr_i  (dbg_addr_i),
    .dbg_wdata_i (dbg_wdata_i),
    .access_go   (access_go),
    .cap_we      (cap_we),
    .cap_addr    (cap_addr),
    .cap_oor     (cap_oor),
    .cap_wdata   (cap_wdata),
    .dbg_ack_o   (dbg_ack_o),
    .dbg_err_o   (dbg_err_o),
    .dbg_busy_o  (dbg_busy_o)
  );

  assign core_wr = wr_en_i && (wr_addr_i != '0);
  // access_go already excludes a concurrent WB write; the reset term keeps a
  // debug write from landing on the reset edge when storage is not reset.
  assign dbg_wr  = access_go && cap_we && !cap_oor && (cap_addr != '0) && !rst_i;

  if (RESET_REGS != 0) begin : g_rst_regs
    always_ff @(posedge clk) begin
      if (rst_i) begin
        for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      end else if (core_wr) begin
        regs[wr_addr_i] <= wr_data_i;
      end else if (dbg_wr) begin
        regs[cap_addr] <= cap_wdata;
      end
    end
  end else begin : g_norst_regs
    always_ff @(posedge clk) begin
      if (core_wr)     regs[wr_addr_i] <= wr_data_i;
      else if (dbg_wr) regs[cap_addr]  <= cap_wdata;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [AW-1:0] addr;
    logic          hit;
    assign addr = rd_addr_i[k*AW +: AW];
    assign hit  = (BYPASS != 0) && wr_en_i && (wr_addr_i == addr);
    // x0 check comes first so a WB write to x0 is never forwarded.
    assign rd_data_o[k*XLEN +: XLEN] = (addr == '0) ? '0 :
                                       hit          ? wr_data_i : regs[addr];
  end

  // Debug read data is held between acks; x0 is forced since its storage
  // slot may be uninitialised when registers are not reset.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else if (access_go && !cap_we && !cap_oor) begin
      rdata_q <= (cap_addr == '0) ? '0 : regs[cap_addr];
    end
  end

  assign dbg_rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_core_regfile_dbg.sv
`default_nettype none
// ============================================================================
// Module   : tb_core_regfile_dbg
// Purpose  : Scoreboard bench for core_regfile_dbg. Two instances share all
//            inputs: one with bypass, one without. Expected core read data
//            and debug responses are queued when stimulus is issued and a
//            negedge monitor pops and compares them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_core_regfile_dbg;

  localparam int XLEN   = 32;
  localparam int NREGS  = 32;
  localparam int AW     = 5;
  localparam int NUM_RD = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   rst_i;
  logic [NUM_RD*AW-1:0]   rd_addr_i;
  logic [NUM_RD*XLEN-1:0] rd_data_b, rd_data_nb;
  logic                   wr_en_i;
  logic [AW-1:0]          wr_addr_i;
  logic [XLEN-1:0]        wr_data_i;
  logic                   halt_i, dbg_req_i, dbg_we_i;
  logic [AW:0]            dbg_addr_i;
  logic [XLEN-1:0]        dbg_wdata_i;
  logic [XLEN-1:0]        dbg_rdata_o, nb_rdata;
  logic                   dbg_ack_o, dbg_err_o, dbg_busy_o;
  logic                   nb_ack, nb_err, nb_busy;

  core_regfile_dbg #(.XLEN(XLEN), .NREGS(NREGS), .NUM_RD(NUM_RD), .BYPASS(1), .RESET_REGS(1)) dut (
    .clk(clk), .rst_i(rst_i), .rd_addr_i(rd_addr_i), .rd_data_o(rd_data_b),
    .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i), .halt_i(halt_i),
    .dbg_req_i(dbg_req_i), .dbg_we_i(dbg_we_i), .dbg_addr_i(dbg_addr_i), .dbg_wdata_i(dbg_wdata_i),
    .dbg_rdata_o(dbg_rdata_o), .dbg_ack_o(dbg_ack_o), .dbg_err_o(dbg_err_o), .dbg_busy_o(dbg_busy_o));

  core_regfile_dbg #(.XLEN(XLEN), .NREGS(NREGS), .NUM_RD(NUM_RD), .BYPASS(0), .RESET_REGS(1)) dut_nb (
    .clk(clk), .rst_i(rst_i), .rd_addr_i(rd_addr_i), .rd_data_o(rd_data_nb),
    .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i), .halt_i(halt_i),
    .dbg_req_i(dbg_req_i), .dbg_we_i(dbg_we_i), .dbg_addr_i(dbg_addr_i), .dbg_wdata_i(dbg_wdata_i),
    .dbg_rdata_o(nb_rdata), .dbg_ack_o(nb_ack), .dbg_err_o(nb_err), .dbg_busy_o(nb_busy));

  typedef struct {
    int          port;
    logic [31:0] exp_b;
    logic [31:0] exp_nb;
  } rd_exp_t;

  typedef struct {
    logic        err;
    logic        chk_data;
    logic [31:0] data;
  } dbg_exp_t;

  rd_exp_t     rdq[$];
  dbg_exp_t    dbgq[$];
  logic [31:0] model [NREGS];
  bit          pin_rd;
  int          n_cmp = 0;
  int          n_fail = 0;
  rd_exp_t     mon_e;
  dbg_exp_t    mon_d;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] stored(input int a);
    if (a <= 0 || a >= NREGS) return '0;
    return model[a];
  endfunction

  // One clock: queue expected core read data for the current inputs, take
  // the edge, apply the core write / reset to the model.
  task automatic tick();
    if (!pin_rd) rd_addr_i = {AW'($urandom), AW'($urandom)};
    for (int k = 0; k < NUM_RD; k++) begin
      int      a;
      rd_exp_t e;
      a        = int'(rd_addr_i[k*AW +: AW]);
      e.port   = k;
      e.exp_nb = stored(a);
      e.exp_b  = (a != 0 && wr_en_i && int'(wr_addr_i) == a) ? wr_data_i : e.exp_nb;
      rdq.push_back(e);
    end
    @(posedge clk);
    if (rst_i) begin
      for (int i = 0; i < NREGS; i++) model[i] = '0;
    end else if (wr_en_i && wr_addr_i != '0) begin
      model[wr_addr_i] = wr_data_i;
    end
    #1;
  endtask

  task automatic sweep();
    pin_rd  = 1'b1;
    wr_en_i = 1'b0;
    for (int i = 0; i < NREGS / 2; i++) begin
      rd_addr_i = {AW'(2 * i + 1), AW'(2 * i)};
      tick();
    end
    pin_rd = 1'b0;
  endtask

  // Full debug transaction with halt_i already high. stall = WB write cycles
  // presented during ACCESS; col_same aims them at the debug address.
  task automatic dbg_op(input logic we, input logic [AW:0] addr, input logic [31:0] wd,
                        input int stall, input bit col_same);
    int       a;
    bit       oor;
    dbg_exp_t x;
    a   = int'(addr);
    oor = (a >= NREGS);
    chk("busy_before_req", dbg_busy_o, 0);
    dbg_req_i = 1'b1; dbg_we_i = we; dbg_addr_i = addr; dbg_wdata_i = wd;
    wr_en_i = 1'b0;
    tick();
    // Scramble the request fields: only the captured copy may be used.
    dbg_we_i = ~we; dbg_addr_i = ~addr; dbg_wdata_i = ~wd;
    for (int s = 0; s < stall; s++) begin
      wr_en_i   = 1'b1;
      wr_addr_i = col_same ? addr[AW-1:0] : AW'($urandom);
      wr_data_i = col_same ? 32'h22 : $urandom;
      chk("ack_during_stall", dbg_ack_o, 0);
      chk("busy_during_stall", dbg_busy_o, 1);
      tick();
    end
    wr_en_i    = 1'b0;
    x.err      = oor;
    x.chk_data = !we && !oor;
    x.data     = stored(a);
    dbgq.push_back(x);
    chk("ack_in_access", dbg_ack_o, 0);
    tick();
    if (we && !oor && a != 0) model[a] = wd;
    chk("ack_latency", dbg_ack_o, 1);
    dbg_req_i = 1'b0;
    pin_rd    = 1'b1;
    rd_addr_i = {AW'($urandom), oor ? AW'(0) : addr[AW-1:0]};
    tick();
    pin_rd = 1'b0;
    chk("ack_one_cycle", dbg_ack_o, 0);
    chk("busy_after_ack", dbg_busy_o, 0);
    chk("busy_after_ack_nb", nb_busy, 0);
  endtask

  // Monitor: compare whatever the DUTs present against the queued model.
  always @(negedge clk) begin
    while (rdq.size() > 0) begin
      mon_e = rdq.pop_front();
      chk($sformatf("rd%0d_bypass", mon_e.port), rd_data_b[mon_e.port*XLEN +: XLEN], mon_e.exp_b);
      chk($sformatf("rd%0d_nobypass", mon_e.port), rd_data_nb[mon_e.port*XLEN +: XLEN], mon_e.exp_nb);
    end
    if (dbg_ack_o) begin
      if (dbgq.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_ack: got ack=1, required ack=0 (t=%0t)", $time);
      end else begin
        mon_d = dbgq.pop_front();
        chk("dbg_err", {31'b0, dbg_err_o}, {31'b0, mon_d.err});
        chk("dbg_err_nb", {31'b0, nb_err}, {31'b0, mon_d.err});
        if (mon_d.chk_data) begin
          chk("dbg_rdata", dbg_rdata_o, mon_d.data);
          chk("dbg_rdata_nb", nb_rdata, mon_d.data);
        end
      end
    end
  end

  initial begin
    rst_i = 1'b1; rd_addr_i = '0; wr_en_i = 1'b0; wr_addr_i = '0; wr_data_i = '0;
    halt_i = 1'b0; dbg_req_i = 1'b0; dbg_we_i = 1'b0; dbg_addr_i = '0; dbg_wdata_i = '0;
    pin_rd = 1'b0;
    for (int i = 0; i < NREGS; i++) model[i] = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_i = 1'b0;

    // Reset state
    chk("rst_ack", dbg_ack_o, 0);
    chk("rst_err", dbg_err_o, 0);
    chk("rst_busy", dbg_busy_o, 0);
    chk("rst_rdata", dbg_rdata_o, 0);
    sweep();

    // Bypass: write x5 with port0 reading x5 in the same cycle
    halt_i    = 1'b1;
    pin_rd    = 1'b1;
    rd_addr_i = {AW'(0), AW'(5)};
    wr_en_i = 1'b1; wr_addr_i = 5'd5; wr_data_i = 32'hDEADBEEF;
    tick();
    wr_en_i = 1'b0;
    tick();
    pin_rd = 1'b0;

    // x0 protection: core write, then debug write of 0x1234
    pin_rd    = 1'b1;
    rd_addr_i = {AW'(0), AW'(0)};
    wr_en_i = 1'b1; wr_addr_i = '0; wr_data_i = 32'h1234;
    tick();
    wr_en_i = 1'b0;
    pin_rd  = 1'b0;
    dbg_op(1'b1, 6'd0, 32'h1234, 0, 1'b0);
    chk("x0_dbg_write_err", dbg_err_o, 0);
    dbg_op(1'b0, 6'd0, 32'h0, 0, 1'b0);

    // Debug read of x7 while halted
    wr_en_i = 1'b1; wr_addr_i = 5'd7; wr_data_i = 32'hA5A5A5A5;
    tick();
    dbg_op(1'b0, 6'd7, 32'h0, 0, 1'b0);

    // Collision: debug write x3 while WB writes x3 for two cycles
    dbg_op(1'b1, 6'd3, 32'h11, 2, 1'b1);
    chk("collision_x3_model", model[3], 32'h11);

    // Out-of-range write and read
    dbg_op(1'b1, 6'd40, 32'hBAD0BAD0, 0, 1'b0);
    dbg_op(1'b0, 6'd40, 32'h0, 1, 1'b0);
    sweep();

    // Wait for halt, abort in ACCESS, then complete
    halt_i = 1'b0; wr_en_i = 1'b0;
    dbg_req_i = 1'b1; dbg_we_i = 1'b1; dbg_addr_i = 6'd9; dbg_wdata_i = 32'hCAFEF00D;
    tick();
    for (int i = 0; i < 10; i++) begin
      chk("wait_busy", dbg_busy_o, 1);
      chk("wait_no_ack", dbg_ack_o, 0);
      tick();
    end
    halt_i = 1'b1;
    tick();
    halt_i = 1'b0;
    tick();
    pin_rd    = 1'b1;
    rd_addr_i = {AW'(0), AW'(9)};
    chk("abort_busy", dbg_busy_o, 1);
    chk("abort_no_ack", dbg_ack_o, 0);
    halt_i = 1'b1;
    tick();
    pin_rd = 1'b0;
    dbgq.push_back('{err: 1'b0, chk_data: 1'b0, data: 32'h0});
    chk("rehalt_no_ack", dbg_ack_o, 0);
    tick();
    model[9] = 32'hCAFEF00D;
    chk("rehalt_ack", dbg_ack_o, 1);
    dbg_req_i = 1'b0;
    pin_rd    = 1'b1;
    rd_addr_i = {AW'(9), AW'(0)};
    tick();
    pin_rd = 1'b0;

    // Randomised mix of core traffic and debug transactions
    for (int n = 0; n < 40; n++) begin
      int idle;
      idle = $urandom_range(0, 2);
      for (int i = 0; i < idle; i++) begin
        wr_en_i   = 1'($urandom);
        wr_addr_i = AW'($urandom);
        wr_data_i = $urandom;
        pin_rd    = 1'b1;
        rd_addr_i = {wr_addr_i, AW'($urandom)};
        tick();
        pin_rd = 1'b0;
      end
      dbg_op(1'($urandom), 6'($urandom_range(0, 40)), $urandom,
             $urandom_range(0, 2), 1'($urandom));
    end

    // Reset during ACCESS abandons the write
    wr_en_i = 1'b0;
    dbg_req_i = 1'b1; dbg_we_i = 1'b1; dbg_addr_i = 6'd12; dbg_wdata_i = 32'h77;
    tick();
    rst_i = 1'b1; dbg_req_i = 1'b0;
    tick();
    rst_i = 1'b0;
    chk("midrst_busy", dbg_busy_o, 0);
    chk("midrst_ack", dbg_ack_o, 0);
    chk("midrst_err", dbg_err_o, 0);
    chk("midrst_rdata", dbg_rdata_o, 0);
    sweep();

    chk("dbg_queue_drained", dbgq.size(), 0);
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
